// File: rtl/rv32_pipeline_pkg.sv
// Shared RV32 pipeline definitions: instruction field positions,
// opcode constants and operand-usage decode.
package rv32_pipeline_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int SB_CNT_W_DEF = 2;
  localparam int REG_W        = 5;

  localparam int OPC_MSB = 6;
  localparam int OPC_LSB = 0;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 7;
  localparam int RS1_MSB = 19;
  localparam int RS1_LSB = 15;
  localparam int RS2_MSB = 24;
  localparam int RS2_LSB = 20;

  typedef logic [6:0] opcode_t;

  localparam opcode_t OPC_OP     = 7'b0110011;
  localparam opcode_t OPC_OP_IMM = 7'b0010011;
  localparam opcode_t OPC_LOAD   = 7'b0000011;
  localparam opcode_t OPC_STORE  = 7'b0100011;
  localparam opcode_t OPC_BRANCH = 7'b1100011;
  localparam opcode_t OPC_JAL    = 7'b1101111;
  localparam opcode_t OPC_JALR   = 7'b1100111;
  localparam opcode_t OPC_LUI    = 7'b0110111;
  localparam opcode_t OPC_AUIPC  = 7'b0010111;
  localparam opcode_t OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
    logic writes_rd;
  } operand_use_t;

  function automatic operand_use_t rv32_operand_use(
    input opcode_t opc
  );
    operand_use_t u;
    u = '0;
    unique case (1'b1)
      (opc == OPC_OP):
        u = operand_use_t'(3'b111);
      (opc == OPC_OP_IMM),
      (opc == OPC_LOAD),
      (opc == OPC_JALR),
      (opc == OPC_SYSTEM):
        u = operand_use_t'(3'b101);
      (opc == OPC_STORE),
      (opc == OPC_BRANCH):
        u = operand_use_t'(3'b110);
      (opc == OPC_LUI),
      (opc == OPC_AUIPC),
      (opc == OPC_JAL):
        u = operand_use_t'(3'b001);
      default:
        u = '0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters with lookup ports and
// sticky underflow error on writeback of an untracked register.
module reg_scoreboard #(
  parameter int N     = 32,
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_valid,
  input  logic [4:0] inc_rd,
  input  logic       dec_valid,
  input  logic [4:0] dec_rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] rd,
  output logic       rs1_busy,
  output logic       rs2_busy,
  output logic       rd_full,
  output logic       err
);

  logic [CNT_W-1:0] cnt [N];
  logic [N-1:1]     inc_hit;
  logic [N-1:1]     dec_hit;
  logic             underflow;

  always_comb begin
    inc_hit = '0;
    dec_hit = '0;
    for (int r = 1; r < N; r++) begin
      inc_hit[r] = inc_valid && (inc_rd == 5'(r));
      dec_hit[r] = dec_valid && (dec_rd == 5'(r));
    end
  end

  // An increment landing on the same register cancels the retire.
  assign underflow = dec_valid && (dec_rd != '0)
    && !(inc_valid && (inc_rd == dec_rd))
    && (cnt[dec_rd] == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N; r++) cnt[r] <= '0;
      err <= 1'b0;
    end else begin
      for (int r = 1; r < N; r++) begin
        if (inc_hit[r] && !dec_hit[r])
          cnt[r] <= cnt[r] + CNT_W'(1);
        else if (dec_hit[r] && !inc_hit[r]
                 && (cnt[r] != '0))
          cnt[r] <= cnt[r] - CNT_W'(1);
      end
      if (underflow) err <= 1'b1;
    end
  end

  assign rs1_busy = (rs1 != '0) && (cnt[rs1] != '0);
  assign rs2_busy = (rs2 != '0) && (cnt[rs2] != '0);
  assign rd_full  = (cnt[rd] == '1);

endmodule

// File: rtl/decode_issue_scoreboard.sv
// Decode stage: one-entry ID register with RAW/structural
// interlock against the pending-write scoreboard.
module decode_issue_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int SB_CNT_W = 2,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_valid_i,
  output logic            fetch_ready_o,
  input  logic [XLEN-1:0] fetch_instr_i,
  input  logic [XLEN-1:0] fetch_pc_i,
  input  logic            flush_i,
  output logic            issue_valid_o,
  input  logic            issue_ready_i,
  output logic [XLEN-1:0] issue_instr_o,
  output logic [XLEN-1:0] issue_pc_o,
  output logic [4:0]      issue_rs1_o,
  output logic [4:0]      issue_rs2_o,
  output logic [4:0]      issue_rd_o,
  output logic            hazard_o,
  input  logic            wb_valid_i,
  input  logic [4:0]      wb_rd_i,
  output logic            err_o
);

  import rv32_pipeline_pkg::*;

  logic            id_valid;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;

  opcode_t         opc;
  operand_use_t    opu;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic            writes;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            rd_full;
  logic            hazard;
  logic            fire;

  assign opc = id_instr[OPC_MSB:OPC_LSB];
  assign rs1 = id_instr[RS1_MSB:RS1_LSB];
  assign rs2 = id_instr[RS2_MSB:RS2_LSB];
  assign rd  = id_instr[RD_MSB:RD_LSB];
  assign opu = rv32_operand_use(opc);

  assign writes = opu.writes_rd && (rd != '0);

  assign hazard = (opu.uses_rs1 && rs1_busy)
    || (opu.uses_rs2 && rs2_busy)
    || (writes && rd_full);

  assign issue_valid_o = id_valid && !hazard && !flush_i;
  assign hazard_o      = id_valid && hazard;
  assign fire          = issue_valid_o && issue_ready_i;
  assign fetch_ready_o = !flush_i && (!id_valid || fire);

  reg_scoreboard #(
    .N     (NUM_REGS),
    .CNT_W (SB_CNT_W)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .inc_valid (fire && writes),
    .inc_rd    (rd),
    .dec_valid (wb_valid_i),
    .dec_rd    (wb_rd_i),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .rd_full   (rd_full),
    .err       (err_o)
  );

  // Data only moves on a fetch handshake, so a stalled offer holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid <= 1'b0;
      id_instr <= '0;
      id_pc    <= '0;
    end else if (flush_i) begin
      id_valid <= 1'b0;
    end else if (fetch_valid_i && fetch_ready_o) begin
      id_valid <= 1'b1;
      id_instr <= fetch_instr_i;
      id_pc    <= fetch_pc_i;
    end else if (fire) begin
      id_valid <= 1'b0;
    end
  end

  assign issue_instr_o = id_instr;
  assign issue_pc_o    = id_pc;
  assign issue_rs1_o   = rs1;
  assign issue_rs2_o   = rs2;
  assign issue_rd_o    = rd;

endmodule

// File: tb/tb_decode_issue_scoreboard.sv
// Directed bench: expected issues queued at fetch, checked by
// a monitor on every issue handshake.
module tb_decode_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_instr_i;
  logic [31:0] fetch_pc_i;
  logic        flush_i;
  logic        issue_valid_o;
  logic        issue_ready_i;
  logic [31:0] issue_instr_o;
  logic [31:0] issue_pc_o;
  logic [4:0]  issue_rs1_o;
  logic [4:0]  issue_rs2_o;
  logic [4:0]  issue_rd_o;
  logic        hazard_o;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  decode_issue_scoreboard dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_valid_i (fetch_valid_i),
    .fetch_ready_o (fetch_ready_o),
    .fetch_instr_i (fetch_instr_i),
    .fetch_pc_i    (fetch_pc_i),
    .flush_i       (flush_i),
    .issue_valid_o (issue_valid_o),
    .issue_ready_i (issue_ready_i),
    .issue_instr_o (issue_instr_o),
    .issue_pc_o    (issue_pc_o),
    .issue_rs1_o   (issue_rs1_o),
    .issue_rs2_o   (issue_rs2_o),
    .issue_rd_o    (issue_rd_o),
    .hazard_o      (hazard_o),
    .wb_valid_i    (wb_valid_i),
    .wb_rd_i       (wb_rd_i),
    .err_o         (err_o)
  );

  function automatic logic [31:0] add(
    input logic [4:0] rd, rs1, rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] addi(
    input logic [4:0] rd, rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] sw(
    input logic [4:0] rs2, rs1);
    return {7'b0, rs2, rs1, 3'b010, 5'b0, 7'b0100011};
  endfunction

  function automatic logic [31:0] lui(
    input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'b0110111};
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr,
                      input logic [31:0] pc,
                      input bit expect_issue);
    fetch_valid_i = 1'b1;
    fetch_instr_i = instr;
    fetch_pc_i    = pc;
    #1;
    chk("fetch_ready", 32'(fetch_ready_o), 32'd1);
    if (expect_issue) q.push_back('{instr, pc});
    tick();
    fetch_valid_i = 1'b0;
    #1;
  endtask

  task automatic do_wb(input logic [4:0] r);
    wb_valid_i = 1'b1;
    wb_rd_i    = r;
    tick();
    wb_valid_i = 1'b0;
    #1;
  endtask

  // Issue monitor: every handshake must match the next queued entry.
  initial begin
    forever begin
      @(negedge clk);
      if (issue_valid_o && issue_ready_i) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue got pc %h expected none",
                   issue_pc_o);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("issue_instr", issue_instr_o, e.instr);
          chk("issue_pc", issue_pc_o, e.pc);
          chk("issue_rd", 32'(issue_rd_o), 32'(e.instr[11:7]));
          chk("issue_rs1", 32'(issue_rs1_o), 32'(e.instr[19:15]));
          chk("issue_rs2", 32'(issue_rs2_o), 32'(e.instr[24:20]));
        end
      end
    end
  end

  initial begin
    rst           = 1'b1;
    fetch_valid_i = 1'b0;
    fetch_instr_i = '0;
    fetch_pc_i    = '0;
    flush_i       = 1'b0;
    issue_ready_i = 1'b1;
    wb_valid_i    = 1'b0;
    wb_rd_i       = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_issue_valid", 32'(issue_valid_o), 32'd0);
    chk("rst_hazard", 32'(hazard_o), 32'd0);
    chk("rst_fetch_ready", 32'(fetch_ready_o), 32'd1);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_instr", issue_instr_o, 32'd0);
    chk("rst_pc", issue_pc_o, 32'd0);
    chk("rst_rd", 32'(issue_rd_o), 32'd0);

    // ADD x3,x1,x2 on an empty scoreboard
    send(add(5'd3, 5'd1, 5'd2), 32'h100, 1);
    chk("add_valid_c1", 32'(issue_valid_o), 32'd1);
    chk("add_rd_c1", 32'(issue_rd_o), 32'd3);
    tick();
    chk("id_empty", 32'(issue_valid_o), 32'd0);

    // ADD x0,x3,x0 sees cnt[3]=1; writeback does not bypass
    send(add(5'd0, 5'd3, 5'd0), 32'h104, 1);
    chk("x3_hazard", 32'(hazard_o), 32'd1);
    chk("x3_no_issue", 32'(issue_valid_o), 32'd0);
    chk("stall_fetch_ready", 32'(fetch_ready_o), 32'd0);
    wb_valid_i = 1'b1;
    wb_rd_i    = 5'd3;
    #1;
    chk("wb_no_bypass", 32'(hazard_o), 32'd1);
    tick();
    wb_valid_i = 1'b0;
    #1;
    chk("x3_released", 32'(hazard_o), 32'd0);
    chk("x3_issue", 32'(issue_valid_o), 32'd1);
    tick();

    // ADDI x5,x0,1 then ADD x6,x5,x5
    send(addi(5'd5, 5'd0, 12'd1), 32'h108, 1);
    tick();
    send(add(5'd6, 5'd5, 5'd5), 32'h10c, 1);
    repeat (2) begin
      chk("x5_hazard", 32'(hazard_o), 32'd1);
      chk("x5_no_issue", 32'(issue_valid_o), 32'd0);
      tick();
    end
    do_wb(5'd5);
    chk("x5_issue", 32'(issue_valid_o), 32'd1);
    tick();
    do_wb(5'd6);

    // Three outstanding writes to x7, fourth stalls
    for (int i = 0; i < 3; i++) begin
      send(addi(5'd7, 5'd0, 12'(i)), 32'h110 + 32'(4 * i), 1);
      tick();
    end
    send(addi(5'd7, 5'd0, 12'd3), 32'h11c, 1);
    chk("x7_full", 32'(hazard_o), 32'd1);
    tick();
    chk("x7_full_hold", 32'(hazard_o), 32'd1);
    do_wb(5'd7);
    chk("x7_release", 32'(issue_valid_o), 32'd1);
    tick();
    repeat (3) do_wb(5'd7);

    // STORE rs2=x9 stalls, then is flushed
    send(addi(5'd9, 5'd0, 12'd1), 32'h120, 1);
    tick();
    send(sw(5'd9, 5'd1), 32'h124, 0);
    chk("store_rs2_hazard", 32'(hazard_o), 32'd1);
    flush_i       = 1'b1;
    fetch_valid_i = 1'b1;
    fetch_instr_i = addi(5'd1, 5'd0, 12'd0);
    fetch_pc_i    = 32'h200;
    #1;
    chk("flush_issue", 32'(issue_valid_o), 32'd0);
    chk("flush_fetch", 32'(fetch_ready_o), 32'd0);
    tick();
    flush_i       = 1'b0;
    fetch_valid_i = 1'b0;
    #1;
    chk("post_flush_valid", 32'(issue_valid_o), 32'd0);
    chk("post_flush_hazard", 32'(hazard_o), 32'd0);
    chk("post_flush_ready", 32'(fetch_ready_o), 32'd1);

    // cnt[9] survives the flush: 1 -> 2 -> 3 (LUI) -> full
    send(addi(5'd9, 5'd0, 12'd2), 32'h128, 1);
    tick();
    send(lui(5'd9, 20'h1), 32'h12c, 1);
    chk("lui_issue", 32'(issue_valid_o), 32'd1);
    tick();
    send(addi(5'd9, 5'd0, 12'd3), 32'h130, 1);
    chk("x9_full", 32'(hazard_o), 32'd1);
    do_wb(5'd9);
    chk("x9_release", 32'(issue_valid_o), 32'd1);
    tick();
    repeat (3) do_wb(5'd9);
    send(addi(5'd0, 5'd9, 12'd0), 32'h134, 1);
    chk("addi_x0_issue", 32'(issue_valid_o), 32'd1);
    tick();
    send(sw(5'd9, 5'd1), 32'h138, 1);
    chk("x9_clear", 32'(hazard_o), 32'd0);
    chk("store_issue", 32'(issue_valid_o), 32'd1);
    tick();

    // Backpressure holds the offer
    issue_ready_i = 1'b0;
    send(add(5'd0, 5'd1, 5'd2), 32'h13c, 1);
    repeat (2) begin
      chk("hold_valid", 32'(issue_valid_o), 32'd1);
      chk("hold_pc", issue_pc_o, 32'h13c);
      tick();
    end
    issue_ready_i = 1'b1;
    tick();

    // Flush kills an otherwise issuable instruction
    issue_ready_i = 1'b0;
    send(add(5'd0, 5'd1, 5'd2), 32'h150, 0);
    issue_ready_i = 1'b1;
    flush_i       = 1'b1;
    #1;
    chk("flush_blocks_issue", 32'(issue_valid_o), 32'd0);
    chk("flush_blocks_fetch", 32'(fetch_ready_o), 32'd0);
    tick();
    flush_i = 1'b0;
    #1;
    chk("flushed_empty", 32'(issue_valid_o), 32'd0);

    // Simultaneous issue and writeback to x4 at cnt=0
    issue_ready_i = 1'b0;
    send(addi(5'd4, 5'd0, 12'd0), 32'h140, 1);
    issue_ready_i = 1'b1;
    wb_valid_i    = 1'b1;
    wb_rd_i       = 5'd4;
    tick();
    wb_valid_i = 1'b0;
    #1;
    chk("inc_dec_no_err", 32'(err_o), 32'd0);
    send(add(5'd0, 5'd4, 5'd0), 32'h144, 1);
    chk("x4_still_zero", 32'(hazard_o), 32'd0);
    tick();
    do_wb(5'd4);
    chk("underflow_err", 32'(err_o), 32'd1);
    repeat (3) tick();
    chk("err_sticky", 32'(err_o), 32'd1);

    repeat (3) tick();
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_issue_scoreboard.md
Name: decode_issue_scoreboard

Overview:
Decode-stage controller between fetch and execute. Holds one fetched instruction in the ID register, tracks in-flight destination registers in a per-register pending-write scoreboard, and issues the instruction only when its source operands carry no outstanding writes (RAW hazard interlock). Releases scoreboard entries on writeback. Accepts flush from branch/exception resolution.

Parameters:
NUM_REGS, 32, architectural integer registers; x0 never tracked
SB_CNT_W, 2, width of each per-register pending counter (maximum 3 outstanding writes per register)
XLEN, 32, PC and instruction width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
fetch_valid_i  in  1  fetch presents an instruction
fetch_ready_o  out  1  ID register can accept this cycle
fetch_instr_i  in  XLEN  instruction word
fetch_pc_i  in  XLEN  instruction PC
flush_i  in  1  kill the ID-register contents
issue_valid_o  out  1  ID instruction hazard-free and offered to execute
issue_ready_i  in  1  execute accepts
issue_instr_o  out  XLEN  held instruction
issue_pc_o  out  XLEN  held PC
issue_rs1_o  out  5  rs1 field
issue_rs2_o  out  5  rs2 field
issue_rd_o  out  5  rd field
hazard_o  out  1  ID valid but blocked by the scoreboard
wb_valid_i  in  1  writeback retires one tracked write
wb_rd_i  in  5  destination being retired
err_o  out  1  sticky: writeback to a register whose counter is 0

Behaviour:
- Reset (rst=1 at clk edge): ID valid=0, all counters=0, err_o=0, all issue_* data=0. issue_valid_o=0, hazard_o=0, fetch_ready_o=1 on the first cycle after reset.
- Fields come from the existing instruction_decode_if layout. Operand usage comes from the opcode:
  - uses_rs1: all opcodes except LUI, AUIPC, JAL.
  - uses_rs2: OP, STORE, BRANCH.
  - writes_rd: OP, OP_IMM, LOAD, LUI, AUIPC, JAL, JALR, SYSTEM. Never when rd=0.
  - Unknown opcode: no uses, no write.
- Hazard (combinational, from current registered counters) is 1 when any of these holds:
  - uses_rs1, rs1≠0, cnt[rs1]≠0
  - uses_rs2, rs2≠0, cnt[rs2]≠0
  - writes_rd and cnt[rd] is at maximum (2^SB_CNT_W−1): structural stall
- issue_valid_o = id_valid & ~hazard & ~flush_i. hazard_o = id_valid & hazard.
- Issue fire = issue_valid_o & issue_ready_i. On fire with writes_rd: cnt[rd] increments next cycle.
- Writeback: wb_valid_i with wb_rd_i≠0 decrements cnt[wb_rd_i] next cycle.
  - wb_rd_i=0 is ignored.
  - Counter already 0: no change, err_o←1 (sticky until rst).
- Same register incremented and decremented in the same cycle: counter unchanged, no error even if it was 0.
- A writeback does not unblock a hazard in the same cycle (no bypass). Earliest issue is the cycle after the writeback.
- fetch_ready_o = ~flush_i & (~id_valid | fire). Fetch handshake (valid&ready) loads the ID register next cycle. Load latency: accepted at cycle N, issue_valid_o possible at N+1.
- While issue_valid_o & ~issue_ready_i, all issue_* outputs hold stable. If the hazard later asserts (only via a counter reaching max, which cannot happen while stalled), the outputs still hold.
- flush_i:
  - Clears id_valid next cycle and blocks issue and fetch acceptance this cycle.
  - Scoreboard is not cleared. Downstream stages must still assert wb_valid_i for every issued write, including killed instructions (null write).
- flush_i and rst together: rst wins.

Decomposition:
- rv32_pipeline_pkg gains:
  - opcode constants (OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_SYSTEM)
  - SB_CNT_W default
  - function rv32_operand_use(opcode) returning a packed struct {uses_rs1, uses_rs2, writes_rd}
- Existing field MSB/LSB constants are reused.
- One sub-module: reg_scoreboard. It holds the counter array with increment/decrement ports, two read-lookup ports plus a full-check port for rd, and err generation.

Test Plan:
- Reset, then ADD x3,x1,x2 with scoreboard empty → fetch accepted at cycle 0, issue_valid_o=1 at cycle 1, issue_rd_o=3, cnt[3]=1 at cycle 2.
- Issue ADDI x5,x0,1, then ADD x6,x5,x5 → hazard_o=1, issue_valid_o=0 until wb_valid_i/wb_rd_i=5. Issue the cycle after the writeback.
- Three outstanding writes to x7, no writeback, then a fourth ADDI x7 → structural stall with hazard_o=1. One writeback to x7 releases it a cycle later.
- STORE using rs2=x9 with cnt[9]=1 → stall. LUI x9 with cnt[9]=2 → issues (no source use), cnt[9]=3. ADDI x0,x9,0 while cnt[9]=0 → issues, no counter change.
- flush_i pulsed while ID holds a stalled instruction → issue_valid_o=0 that cycle, fetch_ready_o=0, id_valid=0 next cycle, counters unchanged.
- wb_valid_i to x4 with cnt[4]=0 → err_o=1 and stays 1. A simultaneous issue to x4 plus writeback x4 at cnt=0 → cnt stays 0, err_o stays 0.
